// File: rtl/float_muldiv.sv
// Iterative floating-point multiplier/divider.
// The format is sign | exponent | mantissa with a hidden leading 1.
// One mantissa bit is resolved per cycle: shift-add for multiply and restoring division for divide.
// Every operation takes the same fixed number of cycles from start to DONE.
module float_muldiv #(
   parameter int BITS     = 16,
   parameter int EXP_BITS = 5
) (
   input  logic            in_clk,
   input  logic            in_rst,
   input  logic [BITS-1:0] in_a,
   input  logic [BITS-1:0] in_b,
   input  logic            in_op,
   input  logic            in_start,
   output logic            out_finished,
   output logic [BITS-1:0] out_result,
   output logic            out_overflow,
   output logic            out_underflow,
   output logic            out_div_zero
);

   localparam int M     = BITS - 1 - EXP_BITS;
   localparam int EW    = EXP_BITS + 2;
   localparam int CNT_W = $clog2(M + 3);

   localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_BITS - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_BITS) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;
   localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(M + 1);
   localparam logic [CNT_W-1:0]     CNT_MUL  = CNT_W'(M);

   typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, DONE} state_t;

   state_t state, state_nx;
   logic   cap_en, prep_en, iter_en, norm_en;

   // Operands captured at start.
   logic [BITS-1:0] a_q, b_q;
   logic            op_q;

   // Working registers for the unpacked operation.
   logic                   sign_q, zero_a_q, zero_b_q;
   logic signed [EW-1:0]   exp_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [M+1:0]           acc_q;
   logic [M:0]             mplier_q;
   logic [M+2:0]           rem_q;
   logic [M+1:0]           quo_q;

   logic signed [EW-1:0]   exp_a, exp_b;
   logic [M:0]             man_a, man_b;
   logic [M+1:0]           acc_sum;
   logic [M+2:0]           div_sub;
   logic                   div_ge;
   logic [M-1:0]           mant_n;
   logic signed [EW-1:0]   exp_n;
   logic [BITS+2:0]        pack_n;

   // Pack a normalised value, saturating to infinity or flushing to zero; result is {ovf, unf, word}.
   function automatic logic [BITS+1:0] saturate(input logic sgn,
                                                input logic signed [EW-1:0] e,
                                                input logic [M-1:0] mant);
      if (e >= EXP_MAX)
         return {2'b10, sgn, EXP_MAX[EXP_BITS-1:0], {M{1'b0}}};
      else if (e <= EXP_ZERO)
         return {2'b01, sgn, {(BITS-1){1'b0}}};
      else
         return {2'b00, sgn, e[EXP_BITS-1:0], mant};
   endfunction

   assign exp_a   = $signed({2'b00, a_q[BITS-2:M]});
   assign exp_b   = $signed({2'b00, b_q[BITS-2:M]});
   assign man_a   = {1'b1, a_q[M-1:0]};
   assign man_b   = {1'b1, b_q[M-1:0]};
   assign acc_sum = acc_q + (mplier_q[0] ? {1'b0, man_a} : '0);
   assign div_ge  = (rem_q >= {2'b00, man_b});
   assign div_sub = rem_q - {2'b00, man_b};

   // State register; reset returns to IDLE from anywhere, abandoning any running operation.
   always_ff @(posedge in_clk) begin
      if (in_rst) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; DONE waits for start to drop so a held start cannot retrigger.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_start) state_nx = PREP;
         PREP:    state_nx = ITER;
         ITER:    if (cnt_q == CNT_LAST) state_nx = NORM;
         NORM:    state_nx = DONE;
         DONE:    if (!in_start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Per-state datapath enables and the finished strobe.
   always_comb begin
      cap_en       = (state == IDLE) && in_start;
      prep_en      = (state == PREP);
      iter_en      = (state == ITER);
      norm_en      = (state == NORM);
      out_finished = (state == DONE);
   end

   // Datapath: capture, unpack, then one mantissa bit per cycle.
   always_ff @(posedge in_clk) begin
      // capture stage
      if (cap_en) begin
         a_q  <= in_a;
         b_q  <= in_b;
         op_q <= in_op;
      end
      // unpack stage
      if (prep_en) begin
         sign_q   <= a_q[BITS-1] ^ b_q[BITS-1];
         zero_a_q <= (a_q[BITS-2:M] == '0);
         zero_b_q <= (b_q[BITS-2:M] == '0);
         exp_q    <= op_q ? (exp_a - exp_b + BIAS) : (exp_a + exp_b - BIAS);
         cnt_q    <= '0;
         acc_q    <= '0;
         mplier_q <= man_b;
         rem_q    <= {2'b00, man_a};
         quo_q    <= '0;
      end
      // iteration stage
      if (iter_en) begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (!op_q) begin
            // The accumulator keeps product bits [2M+1:M]; the bits that are shifted out below can never carry back up.
            // The last multiplier bit is added without a shift.
            // The final spare cycle adds nothing, because the multiplier is then all zeros.
            acc_q    <= (cnt_q < CNT_MUL) ? (acc_sum >> 1) : acc_sum;
            mplier_q <= mplier_q >> 1;
         end else begin
            rem_q <= div_ge ? (div_sub << 1) : (rem_q << 1);
            quo_q <= {quo_q[M:0], div_ge};
         end
      end
   end

   // Normalise by at most one place; the leftover bits are dropped, so the result is truncated.
   always_comb begin
      mant_n = '0;
      exp_n  = exp_q;
      if (!op_q) begin
         if (acc_q[M+1]) begin
            mant_n = acc_q[M:1];
            exp_n  = exp_q + EXP_ONE;
         end else begin
            mant_n = acc_q[M-1:0];
         end
      end else begin
         if (quo_q[M+1]) begin
            mant_n = quo_q[M:1];
         end else begin
            mant_n = quo_q[M-1:0];
            exp_n  = exp_q - EXP_ONE;
         end
      end
   end

   // Special operands take precedence over range saturation; the result is {ovf, unf, div_zero, word}.
   always_comb begin
      pack_n = '0;
      if (op_q && zero_b_q)
         pack_n = {3'b001, sign_q, EXP_MAX[EXP_BITS-1:0], {M{1'b0}}};
      else if (zero_a_q || zero_b_q)
         pack_n = {3'b000, sign_q, {(BITS-1){1'b0}}};
      else
         pack_n = {saturate(sign_q, exp_n, mant_n)[BITS+1:BITS], 1'b0,
                   saturate(sign_q, exp_n, mant_n)[BITS-1:0]};
   end

   // Result and status registers, loaded only on the way into DONE.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_div_zero  <= 1'b0;
      end else if (norm_en) begin
         {out_overflow, out_underflow, out_div_zero, out_result} <= pack_n;
      end
   end

endmodule

// File: tb/tb_float_muldiv.sv
// Directed bench for float_muldiv with the default 16-bit format.
// Expected results are queued when an operation is launched and popped when out_finished rises.
module tb_float_muldiv;

   typedef struct packed {
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        op = 1'b0;
   logic        start = 1'b0;
   logic        finished;
   logic [15:0] result;
   logic        overflow, underflow, div_zero;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   float_muldiv #(.BITS(16), .EXP_BITS(5)) dut (
      .in_clk        (clk),
      .in_rst        (rst),
      .in_a          (a),
      .in_b          (b),
      .in_op         (op),
      .in_start      (start),
      .out_finished  (finished),
      .out_result    (result),
      .out_overflow  (overflow),
      .out_underflow (underflow),
      .out_div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [15:0] r, input logic o, input logic u, input logic d);
      exp_t e;
      e.res = r; e.ovf = o; e.unf = u; e.dz = d;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   // Launch one operation, then scramble the inputs while it runs, and check its latency, result and flags.
   task automatic run_op(input string tag, input logic o, input logic [15:0] av,
                         input logic [15:0] bv, input exp_t e);
      int   lat;
      exp_t got;
      @(negedge clk);
      a = av; b = bv; op = o; start = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      lat = 0;
      while (!finished && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 14);
      got = (sb.size() > 0) ? sb.pop_front() : mk(16'hxxxx, 1'bx, 1'bx, 1'bx);
      check({tag, "_result"}, result, got.res);
      check({tag, "_flags"}, {overflow, underflow, div_zero}, {got.ovf, got.unf, got.dz});
      @(posedge clk); #1;
      check({tag, "_idle"}, finished, 0);
      check({tag, "_hold"}, result, got.res);
   endtask

   initial begin
      int   lat;
      int   seen;
      exp_t got;

      // Reset state.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_finished", finished, 0);
      check("rst_result", result, 0);
      check("rst_flags", {overflow, underflow, div_zero}, 0);

      // Ordinary operations.
      run_op("mul_100x-16", 1'b0, 16'h5640, 16'hCC00, mk(16'hE640, 0, 0, 0));
      run_op("div_1600/-16", 1'b1, 16'hE640, 16'hCC00, mk(16'h5640, 0, 0, 0));
      run_op("div_third", 1'b1, 16'h3C00, 16'h4200, mk(16'h3555, 0, 0, 0));
      run_op("mul_1.5sq", 1'b0, 16'h3E00, 16'h3E00, mk(16'h4080, 0, 0, 0));
      run_op("mul_expmax", 1'b0, 16'h7C00, 16'h3800, mk(16'h7800, 0, 0, 0));
      run_op("div_2/1", 1'b1, 16'h4000, 16'h3C00, mk(16'h4000, 0, 0, 0));

      // Zero operands.
      run_op("div_by0", 1'b1, 16'h3C00, 16'h0000, mk(16'h7C00, 0, 0, 1));
      run_op("div_0by0", 1'b1, 16'h0000, 16'h0000, mk(16'h7C00, 0, 0, 1));
      run_op("mul_negzero", 1'b0, 16'h8000, 16'h4000, mk(16'h8000, 0, 0, 0));
      run_op("div_zero_num", 1'b1, 16'h8000, 16'h4000, mk(16'h8000, 0, 0, 0));

      // Range limits.
      run_op("mul_ovf", 1'b0, 16'h7800, 16'h4000, mk(16'h7C00, 1, 0, 0));
      run_op("mul_unf", 1'b0, 16'h0400, 16'h3800, mk(16'h0000, 0, 1, 0));
      run_op("div_ovf", 1'b1, 16'h7800, 16'h0400, mk(16'h7C00, 1, 0, 0));
      run_op("div_unf", 1'b1, 16'h0400, 16'h7800, mk(16'h0000, 0, 1, 0));

      // A reset in the middle of ITER abandons the operation without producing a result.
      run_op("pre_abort", 1'b0, 16'h5640, 16'hCC00, mk(16'hE640, 0, 0, 0));
      @(negedge clk);
      a = 16'h3C00; b = 16'h4200; op = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("abort_finished", finished, 0);
      check("abort_result", result, 0);
      check("abort_flags", {overflow, underflow, div_zero}, 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (finished) seen++;
      end
      check("abort_no_done", seen, 0);
      run_op("post_abort", 1'b0, 16'h5640, 16'hCC00, mk(16'hE640, 0, 0, 0));

      // Reset wins over a start sampled at the same edge.
      @(negedge clk);
      a = 16'h3C00; b = 16'h3C00; op = 1'b0; start = 1'b1; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (finished) seen++;
      end
      check("rst_priority", seen, 0);
      check("rst_priority_result", result, 0);

      // A start held for 30 cycles runs exactly one operation, and DONE persists until start falls.
      @(negedge clk);
      a = 16'h3C00; b = 16'h4200; op = 1'b1; start = 1'b1;
      sb.push_back(mk(16'h3555, 0, 0, 0));
      @(posedge clk); #1;
      a = 16'h7800; b = 16'h4000; op = 1'b0;
      lat = 0;
      while (!finished && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("held_latency", lat, 14);
      got = (sb.size() > 0) ? sb.pop_front() : mk(16'hxxxx, 1'bx, 1'bx, 1'bx);
      check("held_result", result, got.res);
      seen = 0;
      while (lat < 30) begin
         @(posedge clk); #1;
         lat++;
         if (!finished) seen++;
      end
      check("held_done_stays", seen, 0);
      start = 1'b0;
      @(posedge clk); #1;
      check("held_release", finished, 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (finished) seen++;
      end
      check("held_no_retrigger", seen, 0);
      check("held_hold", result, 16'h3555);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
